// File: rtl/reg_read_stage_if.sv
// rtl/reg_read_stage_if.sv - issue/execute handshake and write-back bus for reg_read_stage
interface reg_read_stage_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6,
    parameter int NWB    = 2,
    parameter int PAY_W  = 137
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_mem;
    logic [IDX_W-1:0]      in_srcA;
    logic [IDX_W-1:0]      in_srcB;
    logic [IDX_W-1:0]      in_dst;
    logic [PAY_W-1:0]      in_payload;

    logic                  out_valid;
    logic                  out_ready;
    logic                  out_mem;
    logic [IDX_W-1:0]      out_srcA;
    logic [IDX_W-1:0]      out_srcB;
    logic [IDX_W-1:0]      out_dst;
    logic [PAY_W-1:0]      out_payload;
    logic [DATA_W-1:0]     out_opA;
    logic [DATA_W-1:0]     out_opB;
    logic [DATA_W-1:0]     out_dstval;

    logic [NWB-1:0]        wb_en;
    logic [NWB*IDX_W-1:0]  wb_idx;
    logic [NWB*DATA_W-1:0] wb_data;

    modport master (
        output in_valid, in_mem, in_srcA, in_srcB, in_dst, in_payload,
        output out_ready, wb_en, wb_idx, wb_data,
        input  in_ready, out_valid, out_mem, out_srcA, out_srcB, out_dst,
        input  out_payload, out_opA, out_opB, out_dstval
    );

    modport slave (
        input  in_valid, in_mem, in_srcA, in_srcB, in_dst, in_payload,
        input  out_ready, wb_en, wb_idx, wb_data,
        output in_ready, out_valid, out_mem, out_srcA, out_srcB, out_dst,
        output out_payload, out_opA, out_opB, out_dstval
    );
endinterface

// File: rtl/reg_read_stage.sv
// rtl/reg_read_stage.sv - register file read stage with write-back bypass and stall refresh
module reg_read_stage #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 64,
    parameter int IDX_W  = 6,
    parameter int NWB    = 2,
    parameter int PAY_W  = 137
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FREEZE,
    reg_read_stage_if.slave   bus
);
    logic [DATA_W-1:0] rf [NREGS];

    // Highest-numbered matching write port wins; out-of-range indices read as zero.
    function automatic logic [DATA_W-1:0] read_byp(input logic [IDX_W-1:0] idx);
        logic [DATA_W-1:0] v;
        v = '0;
        if (int'(idx) < NREGS) begin
            v = rf[idx];
            for (int k = 0; k < NWB; k++) begin
                if (bus.wb_en[k] && bus.wb_idx[k*IDX_W +: IDX_W] == idx)
                    v = bus.wb_data[k*DATA_W +: DATA_W];
            end
        end
        return v;
    endfunction

    logic accept;
    assign bus.in_ready = !FREEZE && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Ascending port order lets the last non-blocking write (highest k) win.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            for (int k = 0; k < NWB; k++) begin
                if (bus.wb_en[k] && int'(bus.wb_idx[k*IDX_W +: IDX_W]) < NREGS)
                    rf[bus.wb_idx[k*IDX_W +: IDX_W]] <= bus.wb_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bus.out_valid   <= 1'b0;
            bus.out_mem     <= 1'b0;
            bus.out_srcA    <= '0;
            bus.out_srcB    <= '0;
            bus.out_dst     <= '0;
            bus.out_payload <= '0;
            bus.out_opA     <= '0;
            bus.out_opB     <= '0;
            bus.out_dstval  <= '0;
        end else if (!FREEZE) begin
            if (accept) begin
                bus.out_valid   <= 1'b1;
                bus.out_mem     <= bus.in_mem;
                bus.out_srcA    <= bus.in_srcA;
                bus.out_srcB    <= bus.in_mem ? '0 : bus.in_srcB;
                bus.out_dst     <= bus.in_dst;
                bus.out_payload <= bus.in_payload;
                bus.out_opA     <= read_byp(bus.in_srcA);
                bus.out_opB     <= bus.in_mem ? '0 : read_byp(bus.in_srcB);
                bus.out_dstval  <= bus.in_mem ? read_byp(bus.in_dst) : '0;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end else if (bus.out_valid) begin
                // Held instruction: pick up results landing while it waits; forced-zero fields stay zero.
                bus.out_opA <= read_byp(bus.out_srcA);
                if (bus.out_mem)
                    bus.out_dstval <= read_byp(bus.out_dst);
                else
                    bus.out_opB <= read_byp(bus.out_srcB);
            end
        end
    end
endmodule

// File: tb/tb_reg_read_stage.sv
// tb/tb_reg_read_stage.sv - directed self-checking bench for reg_read_stage
module tb_reg_read_stage;
    localparam int DATA_W = 32;
    localparam int NREGS  = 48;
    localparam int IDX_W  = 6;
    localparam int NWB    = 2;
    localparam int PAY_W  = 137;

    logic CLK, RESET, FREEZE;
    int   n_checks = 0;
    int   n_errors = 0;

    reg_read_stage_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .NWB(NWB), .PAY_W(PAY_W)) bus ();

    reg_read_stage #(
        .DATA_W(DATA_W), .NREGS(NREGS), .IDX_W(IDX_W), .NWB(NWB), .PAY_W(PAY_W)
    ) dut (
        .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wb(input int k, input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] data);
        bus.wb_en[k] = 1'b1;
        bus.wb_idx[k*IDX_W +: IDX_W] = idx;
        bus.wb_data[k*DATA_W +: DATA_W] = data;
    endtask

    task automatic wb_off();
        bus.wb_en = '0;
    endtask

    task automatic issue(input logic mem, input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b,
                         input logic [IDX_W-1:0] d, input logic [PAY_W-1:0] pay);
        bus.in_valid   = 1'b1;
        bus.in_mem     = mem;
        bus.in_srcA    = a;
        bus.in_srcB    = b;
        bus.in_dst     = d;
        bus.in_payload = pay;
    endtask

    logic [PAY_W-1:0] p1, p3, p5;

    initial begin
        p1 = {9'h1AB, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677};
        p3 = {9'h033, 128'hCAFE_0000_0000_0003};
        p5 = {9'h155, 128'h5555_0000_FFFF_0005};
        RESET = 1'b1; FREEZE = 1'b0;
        bus.in_valid = 1'b0; bus.in_mem = 1'b0; bus.in_srcA = '0; bus.in_srcB = '0;
        bus.in_dst = '0; bus.in_payload = '0; bus.out_ready = 1'b0;
        bus.wb_en = '0; bus.wb_idx = '0; bus.wb_data = '0;
        step(); step();
        RESET = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_opA", bus.out_opA, 0);
        check("rst_payload", bus.out_payload, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // Preload reg5, reg7, then reg6
        wb(0, 5, 32'hDEAD0001); wb(1, 7, 32'h11);
        step();
        wb_off(); wb(0, 6, 32'h55);
        step();
        wb_off();

        // Basic read, non-mem forces dstval to zero
        bus.out_ready = 1'b1;
        issue(0, 5, 7, 6, p1);
        step();
        bus.in_valid = 1'b0;
        check("basic_valid", bus.out_valid, 1);
        check("basic_opA", bus.out_opA, 32'hDEAD0001);
        check("basic_opB", bus.out_opB, 32'h11);
        check("basic_dstval", bus.out_dstval, 0);
        check("basic_payload", bus.out_payload, p1);

        // Same-cycle bypass, higher port wins
        issue(0, 9, 5, 0, 0);
        wb(0, 9, 32'hAAAA); wb(1, 9, 32'hBBBB);
        step();
        wb_off();
        check("byp_opA", bus.out_opA, 32'hBBBB);
        check("byp_opB", bus.out_opB, 32'hDEAD0001);
        issue(0, 9, 9, 0, 0);
        step();
        bus.in_valid = 1'b0;
        check("byp_reg9", bus.out_opA, 32'hBBBB);
        step();
        check("drain_valid", bus.out_valid, 0);

        // Stall with refresh of a held operand
        bus.out_ready = 1'b0;
        issue(0, 5, 3, 0, p3);
        step();
        bus.in_valid = 1'b0;
        check("stall_opB_before", bus.out_opB, 0);
        check("stall_in_ready", bus.in_ready, 0);
        wb(0, 3, 32'h1234);
        step();
        wb_off();
        check("stall_opB_refresh", bus.out_opB, 32'h1234);
        check("stall_payload", bus.out_payload, p3);
        check("stall_valid", bus.out_valid, 1);
        check("stall_in_ready2", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        step();
        check("stall_release", bus.out_valid, 0);

        // Memory op
        issue(1, 5, 4, 6, 0);
        step();
        bus.in_valid = 1'b0;
        check("mem_flag", bus.out_mem, 1);
        check("mem_opB", bus.out_opB, 0);
        check("mem_srcB", bus.out_srcB, 0);
        check("mem_dstval", bus.out_dstval, 32'h55);

        // Out-of-range index: write ignored, read (and bypass) gives zero
        issue(0, 50, 5, 0, 0);
        wb(0, 50, 32'hFFFF);
        step();
        wb_off();
        check("oor_bypass", bus.out_opA, 0);
        issue(0, 50, 5, 0, 0);
        step();
        bus.in_valid = 1'b0;
        check("oor_read", bus.out_opA, 0);

        // Freeze holds outputs even with out_ready=1
        issue(0, 5, 7, 0, p5);
        step();
        bus.in_valid = 1'b0;
        FREEZE = 1'b1;
        wb(0, 2, 32'h77);
        issue(0, 7, 7, 0, p1);
        #1;
        check("frz_in_ready", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("frz_valid", bus.out_valid, 1);
            check("frz_payload", bus.out_payload, p5);
        end
        FREEZE = 1'b0;
        wb_off();
        issue(0, 2, 7, 0, 0);
        step();
        bus.in_valid = 1'b0;
        check("frz_reg2", bus.out_opA, 32'h77);
        step();

        // Reset while holding; reset beats same-cycle write
        bus.out_ready = 1'b0;
        issue(0, 5, 7, 0, p5);
        step();
        bus.in_valid = 1'b0;
        check("rst2_pre_valid", bus.out_valid, 1);
        RESET = 1'b1;
        wb(0, 1, 32'h99);
        step();
        RESET = 1'b0;
        wb_off();
        #1;
        check("rst2_valid", bus.out_valid, 0);
        check("rst2_opA", bus.out_opA, 0);
        check("rst2_payload", bus.out_payload, 0);
        check("rst2_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        issue(0, 5, 1, 0, 0);
        step();
        bus.in_valid = 1'b0;
        check("rst2_reg5", bus.out_opA, 0);
        check("rst2_reg1", bus.out_opB, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reg_read_stage.md
REG_READ_STAGE -- requirements
Module: reg_read_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register and operand width.
REQ-002 SHALL have parameter NREGS, default 64: physical register count.
REQ-003 SHALL have parameter IDX_W, default 6: register index width, with 2**IDX_W >= NREGS.
REQ-004 SHALL have parameter NWB, default 2: number of write-back ports.
REQ-005 SHALL have parameter PAY_W, default 137: opaque payload width (PC, instr, ROB pointer, control bits).
REQ-006 SHALL use one clock with synchronous, active-high reset.
REQ-007 SHALL have port CLK, in, 1: clock, all state updated on rising edge.
REQ-008 SHALL have port RESET, in, 1: synchronous active-high reset.
REQ-009 SHALL have port FREEZE, in, 1: global stall, all state held except RF writes.
REQ-010 SHALL have ports in_valid, in, 1 and in_ready, out, 1: upstream (IQ/LSQ pop) handshake.
REQ-011 SHALL have ports in_mem, in, 1; in_srcA, in_srcB, in_dst, in, IDX_W each; in_payload, in, PAY_W.
REQ-012 SHALL have ports out_valid, out, 1 and out_ready, in, 1: downstream (execute) handshake.
REQ-013 SHALL have ports out_mem, out, 1; out_srcA, out_srcB, out_dst, out, IDX_W each; out_payload, out, PAY_W.
REQ-014 SHALL have ports out_opA, out_opB, out_dstval, out, DATA_W each: operands and store data.
REQ-015 SHALL have ports wb_en, in, NWB; wb_idx, in, NWB*IDX_W; wb_data, in, NWB*DATA_W; port k occupies slice k.

Function
REQ-016 SHALL implement NREGS x DATA_W storage; each wb_en[k] writes wb_data[k] to wb_idx[k] on the clock edge, including during FREEZE.
REQ-017 SHALL resolve same-cycle same-index writes so the highest k wins.
REQ-018 SHALL ignore writes whose wb_idx >= NREGS.
REQ-019 SHALL drive in_ready = !FREEZE && (!out_valid || out_ready), combinationally.
REQ-020 SHALL accept when in_valid && in_ready, capturing payload, indices and in_mem into the output register with 1-cycle latency.
REQ-021 SHALL form each captured operand by bypass: the matching wb_data with highest k if any wb_en[k] && wb_idx[k]==index, else array contents.
REQ-022 SHALL force out_opB=0 and out_srcB=0 when in_mem=1; SHALL force out_dstval=0 when in_mem=0.
REQ-023 SHALL, while out_valid && !out_ready && !FREEZE, refresh any held operand whose out_src index (or out_dst for dstval) matches an active write port, with REQ-017 priority.
REQ-024 SHALL set out_valid: next = accept ? 1 : (out_ready && !FREEZE ? 0 : hold).
REQ-025 SHALL hold every output register unchanged while FREEZE=1, regardless of out_ready.
REQ-026 SHALL hold out_payload and the indices stable while out_valid && !out_ready.
REQ-027 SHALL support back-to-back accepts (one per cycle) when out_ready stays 1.
REQ-028 SHALL treat index values >= NREGS on reads as returning 0.

Reset
REQ-029 SHALL, on RESET=1 at a clock edge, clear out_valid and all output registers to 0 and clear all NREGS entries to 0.
REQ-030 SHALL give RESET priority over FREEZE and over same-cycle wb writes.
REQ-031 SHALL drop an in-flight held instruction on reset, with no replay.
REQ-032 SHALL drive in_ready=1 in the first cycle after reset deasserts, provided FREEZE=0.

Verification
REQ-033 Basic read: write reg5=0xDEAD0001, then accept srcA=5, srcB=7 (reg7=0x11) -> next cycle out_valid=1, opA=0xDEAD0001, opB=0x11.
REQ-034 Bypass plus priority: in the accept cycle drive wb0 {idx 9, 0xAAAA} and wb1 {idx 9, 0xBBBB} with srcA=9 -> opA=0xBBBB; reg9 reads 0xBBBB afterward.
REQ-035 Stall refresh: hold out_ready=0 with srcB=3 captured, then write reg3=0x1234 -> opB becomes 0x1234 next cycle; payload unchanged; in_ready=0.
REQ-036 Mem op: in_mem=1, srcB=4, dst=6 (reg6=0x55) -> opB=0, out_srcB=0, out_dstval=0x55.
REQ-037 FREEZE: out_valid=1, FREEZE=1, out_ready=1 for 3 cycles while writing reg2=0x77 -> outputs frozen, in_ready=0; after release a read of reg2 returns 0x77.
REQ-038 Reset mid-stall: out_valid=1 with out_ready=0, assert RESET -> out_valid=0, all registers 0, in_ready=1 the next cycle.
